fmul_issue_sched: RTL and testbench
===================================

Name: fmul_issue_sched

Overview:
- Schedules a shared, fully pipelined FP multiplier between two issue requesters.
  - Requester 0: the FP issue queue.
  - Requester 1: the FMA/divide sequencer.
- Arbitration is round-robin. The block drives the multiplier operands and the resolved rounding mode.
- A valid/sqN/tag shadow pipeline runs alongside the datapath. Results are buffered in a result FIFO, and branch mispredicts flush younger operations.
- Sits between the issue stage and the FP writeback port.

Parameters:
- LAT, 3: multiplier latency in cycles, from operand drive to mul_result valid (>=1).
- DEPTH, 4: result FIFO entries; also the total credit limit (in-flight + buffered).
- SQN_W, 7: sequence number width.
- TAG_W, 7: destination tag width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- req_valid  in  2  per-requester request
- req_ready  out  2  per-requester accept; combinational
- req_srcA  in  2x32  operand A per requester
- req_srcB  in  2x32  operand B per requester
- req_rm  in  2x3  instruction rounding mode per requester
- req_sqn  in  2xSQN_W  sequence number per requester
- req_tag  in  2xTAG_W  destination tag per requester
- frm  in  3  dynamic rounding mode from fcsr
- br_taken  in  1  branch mispredict flush
- br_sqn  in  SQN_W  sqN of the mispredicted branch
- mul_srcA  out  32  multiplier operand A
- mul_srcB  out  32  multiplier operand B
- mul_rm  out  3  resolved rounding mode
- mul_result  in  32  multiplier result, aligned with shadow stage LAT
- mul_flags  in  5  multiplier exception flags {NV,DZ,OF,UF,NX}
- out_valid  out  1  result available
- out_ready  in  1  writeback accepts
- out_result  out  32  result
- out_flags  out  5  exception flags
- out_illegal  out  1  resolved rm >= 5
- out_tag  out  TAG_W  destination tag
- out_sqn  out  SQN_W  sequence number
- out_src  out  1  originating requester

Behaviour:
- **Reset.** Reset is rst==0 at a clk edge. It clears:
  - all shadow stage valids
  - the FIFO pointers, count and entry valids
  - the round-robin pointer (next priority = requester 0)
  - Outputs after reset: out_valid=0, req_ready=0; data outputs are don't-care.
  - Reset mid-operation discards all in-flight and buffered ops; no output for them.
- **Credits.**
  - used = popcount(shadow stage valids) + FIFO count, sampled at the start of the cycle.
  - space = (used < DEPTH). A pop in the same cycle does not free a credit until the next cycle.
- **Arbitration.**
  - Only one requester valid: it is granted.
  - Both valid: the requester holding priority is granted. Priority toggles to the other requester after each completed grant.
  - req_ready[i] = grant[i] && space && rst. Never both high.
- **Issue (cycle 0).**
  - mul_srcA, mul_srcB and mul_rm are driven combinationally from the granted requester.
  - rm resolution: if req_rm==3'b111 use frm, else use req_rm.
  - On handshake, shadow stage 1 captures {valid, sqn, tag, src, illegal = resolved rm >= 5}.
  - Shadow stages shift every cycle. There are no stalls inside the pipe.
- **Capture (cycle LAT).** When shadow stage LAT is valid, mul_result and mul_flags are written into the FIFO tail together with that stage's fields.
  - Credits guarantee no overflow. An overflow would be an assertion failure.
- **Output.**
  - out_* reflect the FIFO head.
  - out_valid = head present && head entry valid.
  - Pop on out_valid && out_ready.
  - A head entry invalidated by flush is popped automatically without asserting out_valid, one per cycle.
- **Flush.** On br_taken, every op with $signed(sqn - br_sqn) > 0 is killed: shadow stage valids cleared, FIFO entry valids cleared. This applies:
  - in the same cycle, including the stage being captured into the FIFO
  - to an op handshaking this cycle: it completes the handshake (consumed) but is not inserted
  - Ops with sqn == br_sqn or older survive.
  - Killed shadow stages release their credits the next cycle. Killed FIFO entries release their credits when popped.
- **Ordering.** Results leave in issue order. sqN arithmetic is modulo 2^SQN_W with a signed difference.

Test Plan:
- **Single issue, latency.** Reset, then req0 valid with srcA=0x40000000, srcB=0x40400000, rm=0, sqn=5, tag=9, and out_ready=1; mul model returns 0x40C00000. Required: out_valid exactly LAT+1 cycles after the handshake, with result 0x40C00000, tag 9, sqn 5, src 0, illegal 0.
- **Round-robin.** Both requesters valid continuously for 4 cycles, out_ready=1. Required grants in order 0,1,0,1, and no req_ready cycle with both bits set.
- **Credit backpressure.** out_ready=0 while req0 is continuously valid. Required: exactly DEPTH=4 handshakes, then req_ready stays 0. After out_ready is raised, req_ready returns 1 the cycle after the first pop.
- **Branch flush.** Issue sqn 10,11,12,13 back-to-back, then br_taken with br_sqn=11 while 12 and 13 are in the pipe or FIFO. Required: only 10 and 11 appear at the output, and the credits free up.
- **Rounding mode.** req rm=7 with frm=2 gives mul_rm=2 and illegal=0. req rm=7 with frm=5 gives illegal=1. req rm=6 gives illegal=1 regardless of frm.
- **Reset mid-operation.** rst=0 for 1 cycle with 3 ops buffered. Required: out_valid=0 the next cycle, none of the 3 ops is ever output, and full credit of 4 is available.

Source files
------------

// File: rtl/fmul_issue_sched.sv
// Round-robin issue scheduler for a shared pipelined FP multiplier, with a
// valid/sqN/tag shadow pipe, a credit-limited result FIFO and branch flush.
module fmul_issue_sched #(
  parameter int LAT   = 3,
  parameter int DEPTH = 4,
  parameter int SQN_W = 7,
  parameter int TAG_W = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][31:0]      req_srcA,
  input  logic [1:0][31:0]      req_srcB,
  input  logic [1:0][2:0]       req_rm,
  input  logic [1:0][SQN_W-1:0] req_sqn,
  input  logic [1:0][TAG_W-1:0] req_tag,
  input  logic [2:0]            frm,
  input  logic                  br_taken,
  input  logic [SQN_W-1:0]      br_sqn,
  output logic [31:0]           mul_srcA,
  output logic [31:0]           mul_srcB,
  output logic [2:0]            mul_rm,
  input  logic [31:0]           mul_result,
  input  logic [4:0]            mul_flags,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_result,
  output logic [4:0]            out_flags,
  output logic                  out_illegal,
  output logic [TAG_W-1:0]      out_tag,
  output logic [SQN_W-1:0]      out_sqn,
  output logic                  out_src
);

  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int CW   = $clog2(LAT + DEPTH + 1);

  typedef struct packed {
    logic [SQN_W-1:0] sqn;
    logic [TAG_W-1:0] tag;
    logic             src;
    logic             ill;
  } meta_t;

  // An op is younger than the branch when the modular difference is positive.
  function automatic logic younger(input logic [SQN_W-1:0] s,
                                   input logic             tkn,
                                   input logic [SQN_W-1:0] b);
    logic [SQN_W-1:0] d;
    d = s - b;
    return tkn && !d[SQN_W-1] && (d != '0);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic                 rr_q, rr_d;
  logic                 gnt_idx;
  logic [1:0]           grant;
  logic [CW-1:0]        used;
  logic                 space;
  logic                 hs;
  logic [2:0]           rm_res;
  meta_t                iss_meta;
  logic                 iss_kill;

  logic [LAT-1:0]       st_v_q, st_v_d;
  logic [LAT-1:0]       st_kill;
  meta_t                st_q [LAT];

  meta_t                fm_q   [DEPTH];
  logic [31:0]          fres_q [DEPTH];
  logic [4:0]           fflg_q [DEPTH];
  logic [DEPTH-1:0]     fv_q, fv_d;
  logic [DEPTH-1:0]     fkill;
  logic [PW-1:0]        hd_q, hd_d, tl_q, tl_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic                 push, pop, head_present;

  // Arbitration: a lone requester wins, otherwise the priority holder wins.
  always_comb begin
    gnt_idx = rr_q;
    if (req_valid == 2'b01)      gnt_idx = 1'b0;
    else if (req_valid == 2'b10) gnt_idx = 1'b1;
    grant = '0;
    if (req_valid[gnt_idx]) grant[gnt_idx] = 1'b1;
  end

  always_comb begin
    used = CW'(cnt_q);
    for (int i = 0; i < LAT; i++) used = used + CW'(st_v_q[i]);
  end

  assign space     = (used < CW'(DEPTH));
  assign req_ready = grant & {2{space & rst}};
  assign hs        = |(req_valid & req_ready);
  assign rr_d      = hs ? ~gnt_idx : rr_q;

  assign rm_res   = (req_rm[gnt_idx] == 3'b111) ? frm : req_rm[gnt_idx];
  assign mul_srcA = req_srcA[gnt_idx];
  assign mul_srcB = req_srcB[gnt_idx];
  assign mul_rm   = rm_res;

  always_comb begin
    iss_meta.sqn = req_sqn[gnt_idx];
    iss_meta.tag = req_tag[gnt_idx];
    iss_meta.src = gnt_idx;
    iss_meta.ill = (rm_res >= 3'd5);
  end
  assign iss_kill = younger(req_sqn[gnt_idx], br_taken, br_sqn);

  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_st_kill
      assign st_kill[gi] = younger(st_q[gi].sqn, br_taken, br_sqn);
    end
    for (gi = 0; gi < DEPTH; gi++) begin : g_f_kill
      assign fkill[gi] = younger(fm_q[gi].sqn, br_taken, br_sqn);
    end
  endgenerate

  // A flushed op that handshakes this cycle is consumed but never enters the pipe.
  always_comb begin
    st_v_d[0] = hs && !iss_kill;
    for (int i = 1; i < LAT; i++) st_v_d[i] = st_v_q[i-1] && !st_kill[i-1];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st_v_q <= '0;
      rr_q   <= 1'b0;
    end else begin
      st_v_q <= st_v_d;
      rr_q   <= rr_d;
    end
    st_q[0] <= iss_meta;
    for (int i = 1; i < LAT; i++) st_q[i] <= st_q[i-1];
  end

  assign push         = st_v_q[LAT-1] && !st_kill[LAT-1];
  assign head_present = (cnt_q != '0);
  assign out_valid    = head_present && fv_q[hd_q];
  // Flushed head entries drain silently, one per cycle.
  assign pop          = head_present && (!fv_q[hd_q] || out_ready);

  always_comb begin
    fv_d = fv_q & ~fkill;
    hd_d = hd_q;
    tl_d = tl_q;
    if (pop) hd_d = ptr_inc(hd_q);
    if (push) begin
      fv_d[tl_q] = 1'b1;
      tl_d       = ptr_inc(tl_q);
    end
    cnt_d = cnt_q + CNTW'(push) - CNTW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fv_q  <= '0;
      hd_q  <= '0;
      tl_q  <= '0;
      cnt_q <= '0;
    end else begin
      fv_q  <= fv_d;
      hd_q  <= hd_d;
      tl_q  <= tl_d;
      cnt_q <= cnt_d;
      if (push && !pop) assert (cnt_q != CNTW'(DEPTH));
    end
    if (push) begin
      fm_q[tl_q]   <= st_q[LAT-1];
      fres_q[tl_q] <= mul_result;
      fflg_q[tl_q] <= mul_flags;
    end
  end

  assign out_result  = fres_q[hd_q];
  assign out_flags   = fflg_q[hd_q];
  assign out_illegal = fm_q[hd_q].ill;
  assign out_tag     = fm_q[hd_q].tag;
  assign out_sqn     = fm_q[hd_q].sqn;
  assign out_src     = fm_q[hd_q].src;

endmodule

// File: tb/tb_fmul_issue_sched.sv
// Directed bench for fmul_issue_sched: a scoreboard queue is filled on each
// handshake and checked on each output pop; a toy multiplier closes the loop.
module tb_fmul_issue_sched;

  localparam int LAT   = 3;
  localparam int DEPTH = 4;

  logic            clk, rst;
  logic [1:0]      req_valid, req_ready;
  logic [1:0][31:0] req_srcA, req_srcB;
  logic [1:0][2:0] req_rm;
  logic [1:0][6:0] req_sqn, req_tag;
  logic [2:0]      frm;
  logic            br_taken;
  logic [6:0]      br_sqn;
  logic [31:0]     mul_srcA, mul_srcB, mul_result;
  logic [2:0]      mul_rm;
  logic [4:0]      mul_flags;
  logic            out_valid, out_ready, out_illegal, out_src;
  logic [31:0]     out_result;
  logic [4:0]      out_flags;
  logic [6:0]      out_tag, out_sqn;

  fmul_issue_sched #(.LAT(LAT), .DEPTH(DEPTH), .SQN_W(7), .TAG_W(7)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_srcA(req_srcA), .req_srcB(req_srcB), .req_rm(req_rm),
    .req_sqn(req_sqn), .req_tag(req_tag), .frm(frm),
    .br_taken(br_taken), .br_sqn(br_sqn),
    .mul_srcA(mul_srcA), .mul_srcB(mul_srcB), .mul_rm(mul_rm),
    .mul_result(mul_result), .mul_flags(mul_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .out_illegal(out_illegal),
    .out_tag(out_tag), .out_sqn(out_sqn), .out_src(out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Toy multiplier: exponent-style add with bias removal (exact for 2.0*3.0).
  function automatic logic [31:0] fmodel(input logic [31:0] a, input logic [31:0] b);
    return a + b - 32'h3F80_0000;
  endfunction

  logic [31:0] cur_a, cur_b;
  logic [31:0] pa [LAT];
  logic [31:0] pb [LAT];
  always @(posedge clk) begin
    pa[0] <= cur_a;
    pb[0] <= cur_b;
    for (int k = 1; k < LAT; k++) begin
      pa[k] <= pa[k-1];
      pb[k] <= pb[k-1];
    end
  end
  assign mul_result = fmodel(pa[LAT-1], pb[LAT-1]);
  assign mul_flags  = pa[LAT-1][4:0] ^ pb[LAT-1][4:0];

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  flg;
    logic        ill;
    logic [6:0]  tag;
    logic [6:0]  sqn;
    logic        src;
  } exp_t;

  exp_t sb[$];
  int   gnt_log[$];
  int   n_vec, n_miss, hs_cnt, pop_cnt;
  logic [6:0] next_sqn;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_younger(input logic [6:0] s, input logic [6:0] b);
    logic signed [6:0] d;
    d = s - b;
    return d > 7'sd0;
  endfunction

  // One clock: sample mid-low-phase, score, advance to the next negedge.
  task automatic step();
    logic [1:0] adv;
    exp_t       e;
    exp_t       keep[$];
    logic [2:0] r;
    adv = 2'b00;
    #1;
    cur_a = mul_srcA;
    cur_b = mul_srcB;
    check("both_ready", 64'(req_ready == 2'b11), 64'd0);
    if (out_valid && out_ready) begin
      pop_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_out", 64'(out_sqn), 64'h7FFF);
      end else begin
        e = sb.pop_front();
        check("out_result",  64'(out_result),  64'(e.res));
        check("out_flags",   64'(out_flags),   64'(e.flg));
        check("out_illegal", 64'(out_illegal), 64'(e.ill));
        check("out_tag",     64'(out_tag),     64'(e.tag));
        check("out_sqn",     64'(out_sqn),     64'(e.sqn));
        check("out_src",     64'(out_src),     64'(e.src));
      end
    end
    if (br_taken) begin
      foreach (sb[k]) if (!is_younger(sb[k].sqn, br_sqn)) keep.push_back(sb[k]);
      sb = keep;
    end
    for (int i = 0; i < 2; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        hs_cnt++;
        gnt_log.push_back(i);
        adv[i] = 1'b1;
        if (!(br_taken && is_younger(req_sqn[i], br_sqn))) begin
          r     = (req_rm[i] == 3'b111) ? frm : req_rm[i];
          e.res = fmodel(req_srcA[i], req_srcB[i]);
          e.flg = req_srcA[i][4:0] ^ req_srcB[i][4:0];
          e.ill = (r >= 3'd5);
          e.tag = req_tag[i];
          e.sqn = req_sqn[i];
          e.src = (i == 1);
          sb.push_back(e);
        end
      end
    end
    if (!rst) sb.delete();
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (adv[i]) begin
        req_sqn[i]  = next_sqn;
        next_sqn    = next_sqn + 7'd1;
        req_srcA[i] = $urandom;
        req_srcB[i] = $urandom;
        req_tag[i]  = 7'($urandom_range(0, 127));
      end
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 40) begin
      step();
      k++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_out(input int maxc, output int n);
    n = 0;
    #1;
    while (!out_valid && n < maxc) begin
      step();
      n++;
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, h0, p0;
    n_vec = 0; n_miss = 0; hs_cnt = 0; pop_cnt = 0;
    rst = 1'b0; req_valid = 2'b00; out_ready = 1'b0;
    req_srcA = '0; req_srcB = '0; req_rm = '0; req_sqn = '0; req_tag = '0;
    frm = 3'd0; br_taken = 1'b0; br_sqn = '0; next_sqn = 7'd20;
    cur_a = '0; cur_b = '0;

    // Reset: nothing accepted, nothing output.
    @(negedge clk);
    req_valid = 2'b11;
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    step();
    step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    rst = 1'b1;
    req_valid = 2'b00;
    #1;
    check("idle_ready", 64'(req_ready), 64'd0);
    step();

    // Round-robin from reset priority.
    out_ready = 1'b1;
    gnt_log.delete();
    req_valid = 2'b11;
    repeat (4) step();
    req_valid = 2'b00;
    check("rr_count", 64'(gnt_log.size()), 64'd4);
    for (int k = 0; k < 4 && k < gnt_log.size(); k++)
      check($sformatf("rr_grant%0d", k), 64'(gnt_log[k]), 64'(k % 2));
    drain();

    // Single issue and latency (handshake cycle + LAT + 1).
    req_srcA[0] = 32'h4000_0000; req_srcB[0] = 32'h4040_0000;
    req_rm[0] = 3'd0; req_sqn[0] = 7'd5; req_tag[0] = 7'd9;
    next_sqn = 7'd6;
    h0 = hs_cnt;
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    check("t1_handshake", 64'(hs_cnt - h0), 64'd1);
    wait_out(10, n);
    check("t1_latency", 64'(n), 64'(LAT));
    check("t1_result", 64'(out_result), 64'h40C0_0000);
    check("t1_tag", 64'(out_tag), 64'd9);
    check("t1_sqn", 64'(out_sqn), 64'd5);
    check("t1_src", 64'(out_src), 64'd0);
    check("t1_illegal", 64'(out_illegal), 64'd0);
    step();

    // Credit backpressure.
    out_ready = 1'b0;
    h0 = hs_cnt;
    req_valid = 2'b01;
    repeat (12) step();
    check("bp_handshakes", 64'(hs_cnt - h0), 64'(DEPTH));
    #1;
    check("bp_ready_low", 64'(req_ready), 64'd0);
    out_ready = 1'b1;
    #1;
    check("bp_pop_valid", 64'(out_valid), 64'd1);
    check("bp_ready_pop_cycle", 64'(req_ready), 64'd0);
    step();
    #1;
    check("bp_ready_after_pop", 64'(req_ready), 64'd1);
    step();
    req_valid = 2'b00;
    drain();

    // Rounding-mode resolution.
    req_valid = 2'b01;
    req_rm[0] = 3'd7; frm = 3'd2;
    #1;
    check("rm_dyn2", 64'(mul_rm), 64'd2);
    step();
    frm = 3'd5;
    #1;
    check("rm_dyn5", 64'(mul_rm), 64'd5);
    step();
    req_rm[0] = 3'd6; frm = 3'd1;
    #1;
    check("rm_static6", 64'(mul_rm), 64'd6);
    step();
    req_valid = 2'b00;
    req_rm[0] = 3'd0;
    drain();

    // Branch flush: 12 in the FIFO and 13 at capture are killed.
    out_ready = 1'b0;
    req_sqn[0] = 7'd10;
    next_sqn = 7'd11;
    req_valid = 2'b01;
    repeat (4) step();
    req_valid = 2'b00;
    step();
    step();
    br_taken = 1'b1;
    br_sqn = 7'd11;
    step();
    br_taken = 1'b0;
    check("fl_sb_left", 64'(sb.size()), 64'd2);
    out_ready = 1'b1;
    drain();
    out_ready = 1'b0;
    h0 = hs_cnt;
    req_valid = 2'b01;
    repeat (10) step();
    req_valid = 2'b00;
    check("fl_credits", 64'(hs_cnt - h0), 64'(DEPTH));
    out_ready = 1'b1;
    drain();

    // Reset mid-operation with 3 ops buffered.
    out_ready = 1'b0;
    req_valid = 2'b01;
    repeat (3) step();
    req_valid = 2'b00;
    repeat (4) step();
    #1;
    check("rm_pre_valid", 64'(out_valid), 64'd1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check("rmid_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    p0 = pop_cnt;
    repeat (8) step();
    check("rmid_no_output", 64'(pop_cnt - p0), 64'd0);
    out_ready = 1'b0;
    h0 = hs_cnt;
    req_valid = 2'b01;
    repeat (10) step();
    req_valid = 2'b00;
    check("rmid_credits", 64'(hs_cnt - h0), 64'(DEPTH));
    out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
